// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control sequencer for a small 9-bit ISA.
// Steps each instruction through FETCH, DECODE, EXEC and, for loads/stores,
// MEM and WB. It also owns the program counter, the instruction register,
// the cmp flags, a data-memory watchdog and the retired-instruction counter.
module instr_sequencer #(
  parameter int PC_W  = 10,
  parameter int TMO_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] start_addr,
  input  logic [8:0]      instr_i,
  input  logic            dec_regwrite_i,
  input  logic            dec_memwrite_i,
  input  logic            dec_mem2reg_i,
  input  logic            alu_zero_i,
  input  logic            alu_neg_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic            mem_ack_i,
  output logic [PC_W-1:0] pc_o,
  output logic            fetch_o,
  output logic [8:0]      ir_o,
  output logic            reg_we_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [15:0]     icount_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_CMP  = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1000;
  localparam logic [3:0] OP_BGE  = 4'b1010;
  localparam logic [3:0] OP_LDR  = 4'b1101;
  localparam logic [3:0] OP_STR  = 4'b1110;
  localparam logic [3:0] OP_BNE  = 4'b1111;

  // Watchdog value seen in the last permitted ack-less MEM cycle. The count
  // of ack-less cycles reaches 2^TMO_W-1 at the end of this cycle.
  localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t            state;
  state_t            state_next;
  logic [PC_W-1:0]   pc;
  logic [8:0]        ir;
  logic              flag_z;
  logic              flag_n;
  logic [TMO_W-1:0]  wd;
  logic [15:0]       icount;
  logic              err;

  // Control strobes produced by the FSM for the datapath registers.
  logic              load_start;
  logic              load_ir;
  logic              pc_step;
  logic              pc_jump;
  logic              cmp_upd;
  logic              retire;
  logic              wd_inc;
  logic              timeout;

  logic [3:0]        opcode;
  logic              is_mem_op;
  logic              br_taken;

  // Program counter advance, wrapping modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] p);
    return p + PC_W'(1);
  endfunction

  // Retired-instruction counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign opcode    = ir[8:5];
  assign is_mem_op = (opcode == OP_LDR) || (opcode == OP_STR);
  assign br_taken  = ((opcode == OP_BNE) && !flag_z) ||
                     ((opcode == OP_BGE) && !flag_n);

  assign pc_o     = pc;
  assign ir_o     = ir;
  assign err_o    = err;
  assign icount_o = icount;

  // State register; reset forces IDLE regardless of other inputs.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic, Moore outputs and datapath strobes.
  always_comb begin
    state_next = state;
    fetch_o    = 1'b0;
    reg_we_o   = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    load_start = 1'b0;
    load_ir    = 1'b0;
    pc_step    = 1'b0;
    pc_jump    = 1'b0;
    cmp_upd    = 1'b0;
    retire     = 1'b0;
    wd_inc     = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_start = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        busy_o     = 1'b1;
        fetch_o    = 1'b1;
        load_ir    = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        busy_o = 1'b1;
        // A halt leaves the sequencer without being counted as retired.
        if (opcode == OP_HALT) state_next = HALT;
        else                   state_next = EXEC;
      end
      EXEC: begin
        busy_o = 1'b1;
        if (is_mem_op) begin
          // pc stays on the load/store until the access completes.
          state_next = MEM;
        end else begin
          // cmp only updates flags; everything else passes the decoder's write.
          reg_we_o   = (opcode == OP_CMP) ? 1'b0 : dec_regwrite_i;
          cmp_upd    = (opcode == OP_CMP);
          pc_jump    = br_taken;
          pc_step    = !br_taken;
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      MEM: begin
        busy_o    = 1'b1;
        mem_req_o = 1'b1;
        mem_we_o  = dec_memwrite_i;
        // An ack arriving on the terminal watchdog cycle still wins.
        if (mem_ack_i) begin
          if (dec_mem2reg_i) begin
            state_next = WB;
          end else begin
            pc_step    = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
          end
        end else if (wd == WD_LAST) begin
          timeout    = 1'b1;
          state_next = HALT;
        end else begin
          wd_inc = 1'b1;
        end
      end
      WB: begin
        busy_o     = 1'b1;
        reg_we_o   = 1'b1;
        pc_step    = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      HALT: begin
        done_o = 1'b1;
        if (start) begin
          load_start = 1'b1;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Program counter and instruction register; both hold in HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (load_start)   pc <= start_addr;
      else if (pc_jump) pc <= branch_target_i;
      else if (pc_step) pc <= pc_inc(pc);
      if (load_ir) ir <= instr_i;
    end
  end

  // Condition flags captured by cmp and held for later branches.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (cmp_upd) begin
      flag_z <= alu_zero_i;
      flag_n <= alu_neg_i;
    end
  end

  // Memory watchdog: counts ack-less MEM cycles, zero whenever not counting,
  // so it is always clear on entry to MEM.
  always_ff @(posedge clk) begin
    if (reset)       wd <= '0;
    else if (wd_inc) wd <= wd + TMO_W'(1);
    else             wd <= '0;
  end

  // Retire counter and sticky error flag; a new start clears both.
  always_ff @(posedge clk) begin
    if (reset) begin
      icount <= '0;
      err    <= 1'b0;
    end else if (load_start) begin
      icount <= '0;
      err    <= 1'b0;
    end else begin
      if (retire)  icount <= sat_inc(icount);
      if (timeout) err    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: table-driven directed programs, hand-written reset and
// flag sequences, and randomized programs checked against an
// instruction-level reference model.
`timescale 1ns/1ps
module tb_instr_sequencer;
  localparam int PC_W    = 10;
  localparam int TMO_W   = 4;
  localparam int TMO_LIM = (1 << TMO_W) - 1;

  localparam logic [3:0] OP_CMP = 4'b0101, OP_HLT = 4'b1000, OP_BGE = 4'b1010;
  localparam logic [3:0] OP_LDR = 4'b1101, OP_STR = 4'b1110, OP_BNE = 4'b1111;
  localparam logic [8:0] I_ADD = 9'b0000_00011, I_CMP = 9'b0101_00000;
  localparam logic [8:0] I_LDR = 9'b1101_00100, I_STR = 9'b1110_01000;
  localparam logic [8:0] I_BNE = 9'b1111_00001, I_BGE = 9'b1010_00010;
  localparam logic [8:0] I_HLT = 9'b1000_00000, I_NOP = 9'b0000_00000;

  logic            clk = 1'b0;
  logic            reset, start, dec_regwrite_i, dec_memwrite_i, dec_mem2reg_i;
  logic            alu_zero_i, alu_neg_i, mem_ack_i;
  logic [PC_W-1:0] start_addr, branch_target_i, pc_o;
  logic [8:0]      instr_i, ir_o;
  logic            fetch_o, reg_we_o, mem_req_o, mem_we_o, busy_o, done_o, err_o;
  logic [15:0]     icount_o;

  instr_sequencer #(.PC_W(PC_W), .TMO_W(TMO_W)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .instr_i(instr_i), .dec_regwrite_i(dec_regwrite_i),
    .dec_memwrite_i(dec_memwrite_i), .dec_mem2reg_i(dec_mem2reg_i),
    .alu_zero_i(alu_zero_i), .alu_neg_i(alu_neg_i),
    .branch_target_i(branch_target_i), .mem_ack_i(mem_ack_i),
    .pc_o(pc_o), .fetch_o(fetch_o), .ir_o(ir_o), .reg_we_o(reg_we_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .icount_o(icount_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Instruction stream indexed by execution order (not by address).
  logic [8:0]      s_instr[64];
  logic            s_z[64], s_n[64], s_rw[64];
  logic [PC_W-1:0] s_tgt[64];
  int              s_dly[64];
  int              s_len;

  // Observations of one run.
  int o_pcs[$];
  int o_busy, o_regwe, o_memreq, o_memwe;
  // Model predictions of one run.
  int m_pcs[$];
  int m_busy, m_regwe, m_memreq, m_memwe, m_pc, m_ic, m_err, m_ir;

  typedef struct {
    logic [PC_W-1:0] sa;
    int              len;
    logic [35:0]     ins;
    logic [3:0]      z, n, rw;
    logic [PC_W-1:0] tgt;
    int              dly;
    logic [PC_W-1:0] e_pc;
    int              e_ic;
    logic            e_err;
    int              e_regwe, e_memreq, e_memwe, e_busy;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [PC_W-1:0] sa, input int len,
                              input logic [35:0] ins, input logic [3:0] z, n, rw,
                              input logic [PC_W-1:0] tgt, input int dly,
                              input logic [PC_W-1:0] e_pc, input int e_ic,
                              input logic e_err, input int e_regwe, e_memreq,
                              e_memwe, e_busy);
    vec_t v;
    v.sa = sa; v.len = len; v.ins = ins; v.z = z; v.n = n; v.rw = rw;
    v.tgt = tgt; v.dly = dly; v.e_pc = e_pc; v.e_ic = e_ic; v.e_err = e_err;
    v.e_regwe = e_regwe; v.e_memreq = e_memreq; v.e_memwe = e_memwe;
    v.e_busy = e_busy;
    return v;
  endfunction

  function automatic logic [8:0] stream_at(input int k);
    return (k < s_len) ? s_instr[k] : I_HLT;
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; mem_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Plays the environment (ROM, decoder, ALU, memory) for one program run.
  task automatic run_prog(input logic [PC_W-1:0] sa, input bit noise);
    int k, mc, h, cyc;
    logic [8:0] cur;
    o_pcs.delete();
    o_busy = 0; o_regwe = 0; o_memreq = 0; o_memwe = 0;
    k = 0; mc = 0;
    start_addr = sa; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (done_o) break;
      if (busy_o) o_busy++;
      if (mem_req_o) o_memreq++;
      if (fetch_o) begin
        o_pcs.push_back(int'(pc_o));
        instr_i = stream_at(k);
        k++;
        mc = 0;
      end
      h = (k > 0) ? k - 1 : 0;
      cur = stream_at(h);
      dec_regwrite_i  = s_rw[h];
      dec_memwrite_i  = (cur[8:5] == OP_STR);
      dec_mem2reg_i   = (cur[8:5] == OP_LDR);
      alu_zero_i      = s_z[h];
      alu_neg_i       = s_n[h];
      branch_target_i = s_tgt[h];
      if (mem_req_o) begin
        mem_ack_i = (mc == s_dly[h]);
        mc++;
      end else begin
        mem_ack_i = noise && ($urandom_range(0, 1) == 1);
      end
      start = noise && busy_o && ($urandom_range(0, 2) == 0);
      #1;
      if (reg_we_o) o_regwe++;
      if (mem_we_o) o_memwe++;
      @(posedge clk); #1;
    end
    start = 1'b0; mem_ack_i = 1'b0;
    if (!done_o) chk("run_reaches_halt", 0, 1);
  endtask

  // Instruction-level model: one step per instruction, cycle costs by class.
  task automatic model(input logic [PC_W-1:0] sa);
    logic [PC_W-1:0] pc;
    logic fz, fn, taken;
    logic [8:0] ins;
    logic [3:0] op;
    pc = sa; fz = 1'b0; fn = 1'b0;
    m_pcs.delete();
    m_busy = 0; m_regwe = 0; m_memreq = 0; m_memwe = 0; m_ic = 0; m_err = 0;
    for (int k = 0; k < 64; k++) begin
      ins = stream_at(k);
      op = ins[8:5];
      m_pcs.push_back(int'(pc));
      m_ir = int'(ins);
      if (op == OP_HLT) begin
        m_busy += 2;
        break;
      end
      if (op == OP_LDR || op == OP_STR) begin
        if (s_dly[k] >= TMO_LIM) begin
          m_busy += 3 + TMO_LIM;
          m_memreq += TMO_LIM;
          if (op == OP_STR) m_memwe += TMO_LIM;
          m_err = 1;
          break;
        end
        m_busy += 3 + s_dly[k] + 1 + ((op == OP_LDR) ? 1 : 0);
        m_memreq += s_dly[k] + 1;
        if (op == OP_STR) m_memwe += s_dly[k] + 1;
        if (op == OP_LDR) m_regwe++;
        pc = pc + 1'b1;
      end else begin
        m_busy += 3;
        if (op == OP_CMP) begin
          fz = s_z[k]; fn = s_n[k];
        end else if (s_rw[k]) begin
          m_regwe++;
        end
        taken = (op == OP_BNE && !fz) || (op == OP_BGE && !fn);
        pc = taken ? s_tgt[k] : pc + 1'b1;
      end
      if (m_ic < 65535) m_ic++;
    end
    m_pc = int'(pc);
  endtask

  function automatic logic [8:0] rand_instr();
    logic [3:0] op;
    case ($urandom_range(0, 11))
      0, 1, 2, 3: begin
        op = 4'($urandom_range(0, 15));
        if (op == OP_HLT) op = 4'b0110;
      end
      4, 5:    op = OP_CMP;
      6:       op = OP_LDR;
      7:       op = OP_STR;
      8, 9:    op = OP_BNE;
      10:      op = OP_BGE;
      default: op = 4'b0001;
    endcase
    return {op, 5'($urandom_range(0, 31))};
  endfunction

  function automatic int rand_dly();
    int r;
    r = $urandom_range(0, 15);
    if (r < 12)      return r % 4;
    else if (r < 14) return TMO_LIM - 1;
    else             return 40;
  endfunction

  initial begin
    logic [PC_W-1:0] sa;
    int waited;

    //       sa     len ins                               z        n        rw       tgt    dly e_pc   ic err rwe mrq mwe busy
    vt[0]  = mk(5,     2, {I_NOP, I_NOP, I_ADD, I_ADD}, 4'b0000, 4'b0000, 4'b0011, 0,     0,  7,     2, 0, 2,  0,  0,  8);
    vt[1]  = mk('h10,  2, {I_NOP, I_NOP, I_BNE, I_CMP}, 4'b0000, 4'b0000, 4'b0000, 'h20,  0,  'h20,  2, 0, 0,  0,  0,  8);
    vt[2]  = mk('h10,  2, {I_NOP, I_NOP, I_BNE, I_CMP}, 4'b0001, 4'b0000, 4'b0000, 'h20,  0,  'h12,  2, 0, 0,  0,  0,  8);
    vt[3]  = mk('h30,  2, {I_NOP, I_NOP, I_BGE, I_CMP}, 4'b0001, 4'b0000, 4'b0000, 'h100, 0,  'h100, 2, 0, 0,  0,  0,  8);
    vt[4]  = mk('h30,  2, {I_NOP, I_NOP, I_BGE, I_CMP}, 4'b0000, 4'b0001, 4'b0000, 'h100, 0,  'h32,  2, 0, 0,  0,  0,  8);
    vt[5]  = mk(0,     3, {I_NOP, I_BNE, I_ADD, I_CMP}, 4'b0110, 4'b0110, 4'b0010, 'h2A,  0,  'h2A,  3, 0, 1,  0,  0,  11);
    vt[6]  = mk('h40,  1, {I_NOP, I_NOP, I_NOP, I_LDR}, 4'b0000, 4'b0000, 4'b0001, 0,     3,  'h41,  1, 0, 1,  4,  0,  10);
    vt[7]  = mk('h50,  1, {I_NOP, I_NOP, I_NOP, I_STR}, 4'b0000, 4'b0000, 4'b0001, 0,     99, 'h50,  0, 1, 0,  15, 15, 18);
    vt[8]  = mk('h3FF, 1, {I_NOP, I_NOP, I_NOP, I_ADD}, 4'b0000, 4'b0000, 4'b0001, 0,     0,  0,     1, 0, 1,  0,  0,  5);
    vt[9]  = mk('h60,  1, {I_NOP, I_NOP, I_NOP, I_STR}, 4'b0000, 4'b0000, 4'b0000, 0,     0,  'h61,  1, 0, 0,  1,  1,  6);
    vt[10] = mk('h70,  1, {I_NOP, I_NOP, I_NOP, I_LDR}, 4'b0000, 4'b0000, 4'b0000, 0,     14, 'h71,  1, 0, 1,  15, 0,  21);

    for (int i = 0; i < 64; i++) begin
      s_instr[i] = I_NOP; s_z[i] = 1'b0; s_n[i] = 1'b0; s_rw[i] = 1'b0;
      s_tgt[i] = '0; s_dly[i] = 0;
    end
    s_len = 0;
    instr_i = I_NOP; start_addr = '0; branch_target_i = '0;
    alu_zero_i = 1'b0; alu_neg_i = 1'b0; dec_mem2reg_i = 1'b0;

    // Reset dominates start, ack and decoder inputs.
    reset = 1'b1; start = 1'b1; mem_ack_i = 1'b1;
    dec_regwrite_i = 1'b1; dec_memwrite_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc_o, 0);
    chk("rst_ir", ir_o, 0);
    chk("rst_icount", icount_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_reg_we", reg_we_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_fetch", fetch_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    reset = 1'b0; start = 1'b0; mem_ack_i = 1'b0;
    @(posedge clk); #1;

    // Directed programs, run back to back without reset.
    for (int i = 0; i < 11; i++) begin
      s_len = vt[i].len;
      for (int j = 0; j < 4; j++) begin
        s_instr[j] = vt[i].ins[j*9 +: 9];
        s_z[j] = vt[i].z[j]; s_n[j] = vt[i].n[j]; s_rw[j] = vt[i].rw[j];
        s_tgt[j] = vt[i].tgt; s_dly[j] = vt[i].dly;
      end
      run_prog(vt[i].sa, 1'b0);
      chk($sformatf("v%0d_pc", i), pc_o, vt[i].e_pc);
      chk($sformatf("v%0d_icount", i), icount_o, vt[i].e_ic);
      chk($sformatf("v%0d_err", i), err_o, vt[i].e_err);
      chk($sformatf("v%0d_done", i), done_o, 1);
      chk($sformatf("v%0d_busy_o", i), busy_o, 0);
      chk($sformatf("v%0d_reg_we_pulses", i), o_regwe, vt[i].e_regwe);
      chk($sformatf("v%0d_mem_req_cycles", i), o_memreq, vt[i].e_memreq);
      chk($sformatf("v%0d_mem_we_cycles", i), o_memwe, vt[i].e_memwe);
      chk($sformatf("v%0d_busy_cycles", i), o_busy, vt[i].e_busy);
      if (i == 0) begin
        chk("v0_fetch_count", o_pcs.size(), 3);
        for (int j = 0; j < o_pcs.size() && j < 3; j++)
          chk($sformatf("v0_fetch_pc%0d", j), o_pcs[j], 5 + j);
      end
    end

    // Reset in the middle of a memory access abandons it.
    start_addr = 'h0AB; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    instr_i = I_STR; dec_memwrite_i = 1'b1; dec_regwrite_i = 1'b1; mem_ack_i = 1'b0;
    waited = 0;
    while (!mem_req_o && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("mid_mem_reached", mem_req_o, 1);
    @(posedge clk); #1;
    chk("mid_mem_we", mem_we_o, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_mem_req", mem_req_o, 0);
    chk("mid_rst_mem_we", mem_we_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_reg_we", reg_we_o, 0);
    chk("mid_rst_pc", pc_o, 0);
    chk("mid_rst_ir", ir_o, 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_stays_fetch", fetch_o, 0);
    chk("idle_stays_busy", busy_o, 0);

    // Flags come out of reset as 0, so both branches are taken without a cmp.
    s_len = 1; s_instr[0] = I_BNE; s_tgt[0] = 'h77; s_z[0] = 1'b1; s_n[0] = 1'b1; s_rw[0] = 1'b0;
    run_prog('h3, 1'b0);
    chk("rst_flag_bne_pc", pc_o, 'h77);
    do_reset();
    s_instr[0] = I_BGE; s_tgt[0] = 'h155;
    run_prog('h3, 1'b0);
    chk("rst_flag_bge_pc", pc_o, 'h155);

    // Randomized programs against the model; odd runs add start/ack noise.
    for (int r = 0; r < 30; r++) begin
      do_reset();
      s_len = $urandom_range(2, 14);
      for (int i = 0; i < 64; i++) begin
        s_instr[i] = rand_instr();
        s_z[i] = 1'($urandom_range(0, 1));
        s_n[i] = 1'($urandom_range(0, 1));
        s_rw[i] = 1'($urandom_range(0, 1));
        s_tgt[i] = PC_W'($urandom_range(0, (1 << PC_W) - 1));
        s_dly[i] = rand_dly();
      end
      sa = PC_W'($urandom_range(0, (1 << PC_W) - 1));
      model(sa);
      run_prog(sa, (r % 2) == 1);
      chk($sformatf("r%0d_fetch_count", r), o_pcs.size(), m_pcs.size());
      for (int j = 0; j < o_pcs.size() && j < m_pcs.size(); j++)
        chk($sformatf("r%0d_fetch_pc%0d", r, j), o_pcs[j], m_pcs[j]);
      chk($sformatf("r%0d_pc", r), pc_o, m_pc);
      chk($sformatf("r%0d_ir", r), ir_o, m_ir);
      chk($sformatf("r%0d_icount", r), icount_o, m_ic);
      chk($sformatf("r%0d_err", r), err_o, m_err);
      chk($sformatf("r%0d_done", r), done_o, 1);
      chk($sformatf("r%0d_busy_cycles", r), o_busy, m_busy);
      chk($sformatf("r%0d_reg_we_pulses", r), o_regwe, m_regwe);
      chk($sformatf("r%0d_mem_req_cycles", r), o_memreq, m_memreq);
      chk($sformatf("r%0d_mem_we_cycles", r), o_memwe, m_memwe);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
